// File: rtl/user_gpio_bank.sv
// user_gpio_bank
//   Parametrised GPIO bank sitting between the Caravel Wishbone slave port
//   and the user pad bus. Provides per-pin output value and output enable,
//   a synchronised input readback, and per-pin rising/falling edge
//   interrupts folded into a single level interrupt.
//
// Ports
//   wb_clk_i   : single clock for every flop in the block
//   wb_rst_ni  : asynchronous active-low reset
//   wbs_*      : Wishbone classic slave (cyc/stb/we/sel/adr/dat in, dat/ack out)
//   pin_in     : asynchronous pad inputs
//   pin_out    : pad output values (OUT register)
//   pin_oeb    : pad output enables, active low (~OEN register)
//   irq        : OR of all IRQ_STAT bits
//
// Register map (byte offset from BASE_ADDR)
//   0x00 OUT rw | 0x04 OEN rw | 0x08 IN ro | 0x0C RISE_EN rw
//   0x10 FALL_EN rw | 0x14 IRQ_STAT r/w1c | 0x18 OUT_SET wo | 0x1C OUT_CLR wo
//   0x20..0xFC read 0, writes ignored, still acknowledged
module user_gpio_bank #(
  parameter int unsigned NUM_PINS  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] OUT_RESET = 32'h0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic [31:0]         wbs_dat_o,
  output logic                wbs_ack_o,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_oeb,
  output logic                irq
);

  localparam int unsigned W = NUM_PINS;

  localparam logic [5:0] A_OUT  = 6'd0;
  localparam logic [5:0] A_OEN  = 6'd1;
  localparam logic [5:0] A_IN   = 6'd2;
  localparam logic [5:0] A_RISE = 6'd3;
  localparam logic [5:0] A_FALL = 6'd4;
  localparam logic [5:0] A_STAT = 6'd5;
  localparam logic [5:0] A_SET  = 6'd6;
  localparam logic [5:0] A_CLR  = 6'd7;

  // Byte-enable merge for read/write registers.
  function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                         input logic [W-1:0] new_v,
                                         input logic [W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Pin-wide value placed on the 32-bit bus, upper bits zero.
  function automatic logic [31:0] zext(input logic [W-1:0] v);
    logic [31:0] r;
    r        = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  logic           w_sel;
  logic           w_acc;
  logic           w_we;
  logic [5:0]     w_word;
  logic [31:0]    w_bmask;
  logic [31:0]    w_wdata;
  logic [W-1:0]   w_wd;
  logic [W-1:0]   w_wm;
  logic [31:0]    w_rdata;
  logic [W-1:0]   w_rise;
  logic [W-1:0]   w_fall;
  logic [W-1:0]   w_clr;
  logic [W-1:0]   w_stat_nxt;
  logic           w_unused;

  logic [W-1:0]   r_out;
  logic [W-1:0]   r_oen;
  logic [W-1:0]   r_rise_en;
  logic [W-1:0]   r_fall_en;
  logic [W-1:0]   r_stat;
  logic [W-1:0]   r_in_p0;
  logic [W-1:0]   r_in_p1;
  logic [W-1:0]   r_in_p2;
  logic           r_ack;
  logic [31:0]    r_dat;

  always_comb begin
    w_sel   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // Accept only while ack is low so every access is exactly two cycles.
    w_acc   = w_sel & ~r_ack;
    w_we    = w_acc & wbs_we_i;
    w_word  = wbs_adr_i[7:2];
    w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
               {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    w_wdata = wbs_dat_i & w_bmask;
    w_wd    = w_wdata[W-1:0];
    w_wm    = w_bmask[W-1:0];

    unique case (w_word)
      A_OUT:   w_rdata = zext(r_out);
      A_OEN:   w_rdata = zext(r_oen);
      A_IN:    w_rdata = zext(r_in_p1);
      A_RISE:  w_rdata = zext(r_rise_en);
      A_FALL:  w_rdata = zext(r_fall_en);
      A_STAT:  w_rdata = zext(r_stat);
      default: w_rdata = '0;
    endcase

    w_rise     = r_in_p1 & ~r_in_p2 & r_rise_en;
    w_fall     = ~r_in_p1 & r_in_p2 & r_fall_en;
    w_clr      = (w_we && (w_word == A_STAT)) ? w_wd : '0;
    // New events are ORed in after the clear so a same-cycle set wins.
    w_stat_nxt = (r_stat & ~w_clr) | w_rise | w_fall;
  end

  // Address LSBs and bits above NUM_PINS carry no meaning here.
  assign w_unused = &{1'b0, wbs_adr_i[1:0], w_wdata, w_bmask};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_out     <= OUT_RESET[W-1:0];
      r_oen     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_stat    <= '0;
      r_in_p0   <= '0;
      r_in_p1   <= '0;
      r_in_p2   <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
    end else begin
      // Stage p0/p1: two-flop synchroniser; p2: previous p1 for edge detect.
      r_in_p0   <= pin_in;
      r_in_p1   <= r_in_p0;
      r_in_p2   <= r_in_p1;
      r_stat    <= w_stat_nxt;
      r_ack     <= w_acc;
      r_dat     <= w_acc ? w_rdata : '0;
      if (w_we) begin
        unique case (w_word)
          A_OUT:   r_out     <= merge(r_out, w_wd, w_wm);
          A_OEN:   r_oen     <= merge(r_oen, w_wd, w_wm);
          A_RISE:  r_rise_en <= merge(r_rise_en, w_wd, w_wm);
          A_FALL:  r_fall_en <= merge(r_fall_en, w_wd, w_wm);
          A_SET:   r_out     <= r_out | w_wd;
          A_CLR:   r_out     <= r_out & ~w_wd;
          default: ;
        endcase
      end
    end
  end

  assign pin_out   = r_out;
  assign pin_oeb   = ~r_oen;
  assign irq       = |r_stat;
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_user_gpio_bank.sv
module tb_user_gpio_bank;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = 4'h0;
  logic [31:0] adr   = 32'h0;
  logic [31:0] wdat  = 32'h0;
  logic [31:0] pin   = 32'h0;
  logic [7:0]  pin8  = 8'h0;

  logic [31:0] dat_o, dat8_o;
  logic        ack, ack8;
  logic [31:0] pout, poeb;
  logic [7:0]  pout8, poeb8;
  logic        irq, irq8;

  always #5 clk = ~clk;

  user_gpio_bank #(.NUM_PINS(32), .BASE_ADDR(BASE), .OUT_RESET(32'h0)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .pin_in(pin), .pin_out(pout), .pin_oeb(poeb), .irq(irq)
  );

  user_gpio_bank #(.NUM_PINS(8), .BASE_ADDR(BASE), .OUT_RESET(32'h0)) dut8 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat8_o), .wbs_ack_o(ack8),
    .pin_in(pin8), .pin_out(pout8), .pin_oeb(poeb8), .irq(irq8)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: register values plus a history of sampled pin values.
  logic [31:0] m_out, m_oen, m_rise, m_fall, m_stat, m_dat;
  logic        m_ack;
  logic [31:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_out = 32'h0; m_oen = 32'h0; m_rise = 32'h0; m_fall = 32'h0;
    m_stat = 32'h0; m_dat = 32'h0; m_ack = 1'b0;
    hist.delete();
    repeat (3) hist.push_back(32'h0);
  endtask

  // One clock edge: predict, wait for the edge, update model, compare.
  task automatic step();
    logic [31:0] synced, prev, wm, d, rdv, clr, rise_old, fall_old, p;
    logic        acc;
    logic [5:0]  w;
    // Value seen by the bank is the pin sampled two edges back; the one
    // before that is used for edge detection.
    synced   = hist[hist.size()-2];
    prev     = hist[hist.size()-3];
    acc      = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
    w        = adr[7:2];
    wm       = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    d        = wdat & wm;
    p        = pin;
    rise_old = m_rise;
    fall_old = m_fall;
    case (w)
      6'd0: rdv = m_out;
      6'd1: rdv = m_oen;
      6'd2: rdv = synced;
      6'd3: rdv = m_rise;
      6'd4: rdv = m_fall;
      6'd5: rdv = m_stat;
      default: rdv = 32'h0;
    endcase
    clr = 32'h0;
    @(posedge clk);
    hist.push_back(p);
    if (hist.size() > 4) void'(hist.pop_front());
    if (acc && we) begin
      case (w)
        6'd0: m_out  = (m_out  & ~wm) | d;
        6'd1: m_oen  = (m_oen  & ~wm) | d;
        6'd3: m_rise = (m_rise & ~wm) | d;
        6'd4: m_fall = (m_fall & ~wm) | d;
        6'd5: clr    = d;
        6'd6: m_out  = m_out | d;
        6'd7: m_out  = m_out & ~d;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~clr) | (synced & ~prev & rise_old) | (~synced & prev & fall_old);
    m_ack  = acc;
    m_dat  = acc ? rdv : 32'h0;
    #1;
    chk("ack", 32'(ack), 32'(m_ack));
    chk("dat_o", dat_o, m_dat);
    chk("pin_out", pout, m_out);
    chk("pin_oeb", poeb, ~m_oen);
    chk("irq", 32'(irq), 32'(|m_stat));
  endtask

  task automatic bus(input logic w_en, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r, output logic a_ack);
    cyc = 1'b1; stb = 1'b1; we = w_en; adr = a; sel = s; wdat = d;
    step();
    r = dat_o; a_ack = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; logic a;
    bus(1'b1, BASE + 32'(off), s, d, r, a);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    logic a;
    bus(1'b0, BASE + 32'(off), 4'hF, 32'h0, r, a);
  endtask

  initial begin
    logic [31:0] r;
    logic        a;
    model_reset();

    // Reset state
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_oeb", poeb, 32'hFFFF_FFFF);
    chk("rst_out", pout, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int o = 0; o < 9; o++) begin
      bus(1'b0, BASE + 32'(o * 4), 4'hF, 32'h0, r, a);
      chk("rst_rd_ack", 32'(a), 32'h1);
      chk("rst_rd", r, 32'h0);
    end

    // Output and enable path
    wr(8'h04, 32'h0000_00F0, 4'hF);
    wr(8'h00, 32'h0000_00A5, 4'hF);
    wr(8'h18, 32'h0000_0100, 4'hF);
    wr(8'h1C, 32'h0000_0001, 4'hF);
    chk("oeb_path", poeb, 32'hFFFF_FF0F);
    chk("out_path", pout, 32'h0000_01A4);
    wr(8'h00, 32'hFFFF_FFFF, 4'b0010);
    chk("out_bytesel", pout, 32'h0000_FFA4);

    // Input synchroniser latency: continuous reads of IN after pin 3 rises
    pin = 32'h8;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h8; sel = 4'hF;
    step();
    chk("in_early", dat_o, 32'h0);
    step();
    step();
    chk("in_late", dat_o, 32'h8);
    cyc = 1'b0; stb = 1'b0;
    step();

    // Rising-edge interrupt, W1C, and a falling edge with FALL_EN off
    pin = 32'h0;
    repeat (4) step();
    wr(8'h0C, 32'h8, 4'hF);
    pin = 32'h8;
    step(); step();
    chk("rise_irq_early", 32'(irq), 32'h0);
    step();
    chk("rise_irq", 32'(irq), 32'h1);
    rd(8'h14, r);
    chk("rise_stat", r, 32'h8);
    wr(8'h14, 32'h8, 4'hF);
    chk("w1c_irq", 32'(irq), 32'h0);
    pin = 32'h0;
    repeat (5) step();
    chk("fall_off_irq", 32'(irq), 32'h0);
    rd(8'h14, r);
    chk("fall_off_stat", r, 32'h0);

    // Clear and new rise on the same edge: set wins
    pin = 32'h8;
    step(); step();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h14; sel = 4'hF; wdat = 32'h8;
    step();
    chk("collide_irq", 32'(irq), 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
    rd(8'h14, r);
    chk("collide_stat", r, 32'h8);
    wr(8'h14, 32'hFFFF_FFFF, 4'hF);
    chk("collide_clr", 32'(irq), 32'h0);

    // Decode boundaries
    bus(1'b0, BASE + 32'h40, 4'hF, 32'h0, r, a);
    chk("hole_ack", 32'(a), 32'h1);
    chk("hole_dat", r, 32'h0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h100; sel = 4'hF; wdat = 32'hFFFF_FFFF;
    repeat (10) begin
      step();
      chk("noack", 32'(ack), 32'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) pin = $urandom;
      repeat ($urandom_range(0, 2)) step();
      bus(1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 9) * 4),
          4'($urandom), $urandom, r, a);
    end

    // Asynchronous reset mid-cycle clears everything
    wr(8'h0C, 32'hFFFF_FFFF, 4'hF);
    wr(8'h04, 32'h0000_FFFF, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'h0);
    chk("arst_oeb", poeb, 32'hFFFF_FFFF);
    chk("arst_out", pout, 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pin = 32'h0;
    rd(8'h0C, r);
    chk("arst_rise_en", r, 32'h0);

    // Narrow build: bits above NUM_PINS read 0
    wr(8'h00, 32'hFFFF_FFFF, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    step();
    chk("n8_ack", 32'(ack8), 32'h1);
    chk("n8_out_rd", dat8_o, 32'h0000_00FF);
    chk("n8_pin_out", 32'(pout8), 32'h0000_00FF);
    chk("n32_out_rd", dat_o, 32'hFFFF_FFFF);
    cyc = 1'b0; stb = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
